// File: rtl/inta_sequencer.sv
// inta_sequencer: 8086-side initiator of the 8259 two-pulse INTA handshake with vector capture.
// Optional `define INTA_LOCK_EN drives lock_n low from the first INTA pulse through the second.
module inta_sequencer #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_req,
  input  logic       int_en,
  input  logic [7:0] data_in,
  output logic       inta_n,
  output logic       first_ack,
  output logic       second_ack,
  output logic [7:0] vec_out,
  output logic       vec_valid,
  output logic       busy,
  output logic       lock_n
);

  typedef enum logic [2:0] {
    IDLE,
    P1,
    GAP,
    P2,
    DONE,
    RECOVER
  } stateType;

  localparam logic [3:0] pulseLoad = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] gapLoad   = 4'(GAP_CYCLES - 1);

  stateType   state;
  stateType   nextState;
  logic [3:0] count;
  logic [3:0] nextCount;
  logic       countZero;
  logic       startReq;
  logic       capture;

  assign countZero = (count == 4'd0);
  assign startReq  = int_req && int_en;

  always_comb begin
    // NOTE: defaults first, so every path through the case assigns every signal and no latch is inferred.
    nextState = state;
    nextCount = countZero ? 4'd0 : count - 4'd1;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (startReq) begin
          nextState = P1;
          nextCount = pulseLoad;
        end
      end
      P1: begin
        if (countZero) begin
          nextState = GAP;
          nextCount = gapLoad;
        end
      end
      GAP: begin
        if (countZero) begin
          nextState = P2;
          nextCount = pulseLoad;
        end
      end
      P2: begin
        if (countZero) begin
          nextState = DONE;
          nextCount = 4'd0;
          capture   = 1'b1;
        end
      end
      DONE: begin
        nextState = RECOVER;
        nextCount = gapLoad;
      end
      RECOVER: begin
        // The final recovery edge doubles as the IDLE sampling edge, giving a 2P+2G+1 period.
        if (countZero) begin
          if (startReq) begin
            nextState = P1;
            nextCount = pulseLoad;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: begin
        nextState = IDLE;
        nextCount = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from nextState and registered, so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 4'd0;
      inta_n     <= 1'b1;
      first_ack  <= 1'b0;
      second_ack <= 1'b0;
      vec_out    <= 8'h00;
      vec_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees the pre-edge values.
      state      <= nextState;
      count      <= nextCount;
      inta_n     <= !(nextState == P1 || nextState == P2);
      first_ack  <= (nextState == P1);
      second_ack <= (nextState == P2);
      vec_valid  <= capture;
      busy       <= (nextState != IDLE);
      if (capture) begin
        vec_out <= data_in;
      end
    end
  end

`ifdef INTA_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_n <= 1'b1;
    end else begin
      lock_n <= !(nextState == P1 || nextState == GAP || nextState == P2);
    end
  end
`else
  assign lock_n = 1'b1;
`endif

endmodule
